// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared multiply/divide operator and host FSM types
package ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_HOST_IDLE = 2'b00,
    MD_HOST_BUSY = 2'b01,
    MD_HOST_RESP = 2'b10
  } md_host_state_e;

  function automatic logic md_op_is_mult(md_op_e op);
    return (op == MD_OP_MULL) || (op == MD_OP_MULH);
  endfunction

endpackage

// File: rtl/ibex_multdiv_host_if.sv
// rtl/ibex_multdiv_host_if.sv - decode request / writeback response bundle of the multdiv host
interface ibex_multdiv_host_if;
  import ibex_pkg::*;

  logic        req_valid;
  logic        req_ready;
  md_op_e      req_op;
  logic [1:0]  req_signed_mode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, req_op, req_signed_mode, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_signed_mode, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/ibex_multdiv_host_adder.sv
// rtl/ibex_multdiv_host_adder.sv - 34-bit shared adder and zero flag lent to the slow multdiv
module ibex_multdiv_host_adder (
  input  logic [32:0] operand_a_i,
  input  logic [32:0] operand_b_i,
  output logic [33:0] adder_ext_o,
  output logic [31:0] adder_o,
  output logic        equal_to_zero_o
);

  assign adder_ext_o     = {1'b0, operand_a_i} + {1'b0, operand_b_i};
  assign adder_o         = adder_ext_o[32:1];
  assign equal_to_zero_o = (adder_o == 32'd0);

endmodule

// File: rtl/ibex_multdiv_host.sv
// rtl/ibex_multdiv_host.sv - issue/host side of the slow multiply/divide datapath
// MD_DATA_IND_TIMING_EN forces data-independent timing regardless of cfg_data_ind_timing_i.
module ibex_multdiv_host
  import ibex_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  ibex_multdiv_host_if.slave host,
  input  logic               cfg_data_ind_timing_i,

  output logic               mult_en_o,
  output logic               div_en_o,
  output logic               mult_sel_o,
  output logic               div_sel_o,
  output md_op_e             operator_o,
  output logic [1:0]         signed_mode_o,
  output logic [31:0]        op_a_o,
  output logic [31:0]        op_b_o,
  output logic               data_ind_timing_o,
  output logic               multdiv_ready_id_o,
  output logic [33:0]        alu_adder_ext_o,
  output logic [31:0]        alu_adder_o,
  output logic               equal_to_zero_o,
  output logic [33:0]        imd_val_q_o [2],

  input  logic [32:0]        alu_operand_a_i,
  input  logic [32:0]        alu_operand_b_i,
  input  logic [33:0]        imd_val_d_i [2],
  input  logic [1:0]         imd_val_we_i,
  input  logic               valid_i,
  input  logic [31:0]        result_i
);

  md_host_state_e state_q, state_d;
  md_op_e         op_q;
  logic [1:0]     signed_mode_q;
  logic [31:0]    op_a_q, op_b_q;
  logic [31:0]    rsp_data_q;
  logic           accept;
  logic           busy;

  assign busy           = (state_q == MD_HOST_BUSY);
  assign host.req_ready = (state_q == MD_HOST_IDLE) |
                          ((state_q == MD_HOST_RESP) & host.rsp_ready);
  assign accept         = host.req_valid & host.req_ready;

  always_comb begin
    state_d            = state_q;
    mult_en_o          = 1'b0;
    mult_sel_o         = 1'b0;
    div_en_o           = 1'b0;
    div_sel_o          = 1'b0;
    multdiv_ready_id_o = 1'b0;
    unique case (state_q)
      MD_HOST_IDLE: begin
        if (accept) state_d = MD_HOST_BUSY;
      end
      MD_HOST_BUSY: begin
        mult_en_o          = md_op_is_mult(op_q);
        mult_sel_o         = md_op_is_mult(op_q);
        div_en_o           = ~md_op_is_mult(op_q);
        div_sel_o          = ~md_op_is_mult(op_q);
        multdiv_ready_id_o = 1'b1;
        if (valid_i) state_d = MD_HOST_RESP;
      end
      MD_HOST_RESP: begin
        if (host.rsp_ready) state_d = accept ? MD_HOST_BUSY : MD_HOST_IDLE;
      end
      default: state_d = MD_HOST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= MD_HOST_IDLE;
      op_q          <= MD_OP_MULL;
      signed_mode_q <= 2'b00;
      op_a_q        <= 32'd0;
      op_b_q        <= 32'd0;
      rsp_data_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q          <= host.req_op;
        signed_mode_q <= host.req_signed_mode;
        op_a_q        <= host.req_a;
        op_b_q        <= host.req_b;
      end
      if (busy && valid_i) rsp_data_q <= result_i;
    end
  end

  // The multdiv keeps its operands across its whole iteration, so only latched copies are exposed.
  assign operator_o     = op_q;
  assign signed_mode_o  = signed_mode_q;
  assign op_a_o         = op_a_q;
  assign op_b_o         = op_b_q;
  assign host.rsp_valid = (state_q == MD_HOST_RESP);
  assign host.rsp_data  = rsp_data_q;

`ifdef MD_DATA_IND_TIMING_EN
  assign data_ind_timing_o = 1'b1;
`else
  logic dit_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dit_q <= 1'b0;
    end else if (accept) begin
      dit_q <= cfg_data_ind_timing_i;
    end
  end

  assign data_ind_timing_o = dit_q;
`endif

  // Intermediate values survive between operations; the multdiv reinitialises them itself.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      imd_val_q_o[0] <= 34'd0;
      imd_val_q_o[1] <= 34'd0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (imd_val_we_i[k] && (mult_en_o || div_en_o)) imd_val_q_o[k] <= imd_val_d_i[k];
      end
    end
  end

  ibex_multdiv_host_adder u_adder (
    .operand_a_i     (alu_operand_a_i),
    .operand_b_i     (alu_operand_b_i),
    .adder_ext_o     (alu_adder_ext_o),
    .adder_o         (alu_adder_o),
    .equal_to_zero_o (equal_to_zero_o)
  );

endmodule
